// File: rtl/freq_monitor_multi.sv
// freq_monitor_multi
// Multi-channel reference-frequency qualifier. Each channel synchronises a foreign
// toggle signal and counts its edges over a shared 2**GATE_W cycle gate. The count
// is compared with per-channel limits, and a hysteresis counter filters the result
// into freq_valid. A per-channel timer flags loss of signal when edges stop arriving.
module freq_monitor_multi #(
  parameter int NUM_CH      = 2,
  parameter int GATE_W      = 8,
  parameter int COUNT_W     = 8,
  parameter int HYST_W      = 3,
  parameter int SYNC_STAGES = 3,
  parameter int LOS_CYCLES  = 64
) (
  input  logic                        clk_10mhz_ext_bufg,
  input  logic                        rst_250mhz_int,
  input  logic [NUM_CH-1:0]           tog_in,
  input  logic [NUM_CH*COUNT_W-1:0]   cfg_valid_min,
  input  logic [NUM_CH*COUNT_W-1:0]   cfg_valid_max,
  input  logic [NUM_CH*COUNT_W-1:0]   cfg_invalid_min,
  input  logic [NUM_CH*COUNT_W-1:0]   cfg_invalid_max,
  output logic [NUM_CH*COUNT_W-1:0]   meas_count,
  output logic                        meas_strobe,
  output logic [NUM_CH-1:0]           freq_valid,
  output logic [NUM_CH-1:0]           los
);

  localparam int                 LOS_W   = $clog2(LOS_CYCLES + 1);
  localparam logic [LOS_W-1:0]   LOS_TC  = LOS_W'(LOS_CYCLES);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [HYST_W-1:0]  HYST_MAX = {HYST_W{1'b1}};

  // Core reset: asserted asynchronously with the input, released two clocks later.
  logic [1:0] rst_pipe;
  logic       core_rst_b;

  // Reset release synchroniser.
  always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_250mhz_int) begin
    if (rst_250mhz_int) rst_pipe <= '0;
    else                rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign core_rst_b = rst_pipe[1];

  logic [GATE_W-1:0] gate_q;
  logic              eval;

  // Shared free-running gate counter; the all-ones cycle closes each window.
  always_ff @(posedge clk_10mhz_ext_bufg or negedge core_rst_b) begin
    if (!core_rst_b) gate_q <= '0;
    else             gate_q <= gate_q + GATE_W'(1);
  end

  assign eval = &gate_q;

  // Strobe marks the cycle in which the freshly captured counts are visible.
  always_ff @(posedge clk_10mhz_ext_bufg or negedge core_rst_b) begin
    if (!core_rst_b) meas_strobe <= 1'b0;
    else             meas_strobe <= eval;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_det;
    logic [COUNT_W-1:0]     cnt_q;
    logic [COUNT_W-1:0]     cnt_inc;
    logic [COUNT_W-1:0]     meas_q;
    logic [HYST_W-1:0]      hyst_q;
    logic                   valid_q;
    logic                   los_q;
    logic [LOS_W-1:0]       timer_q;
    logic                   los_hit;
    logic [COUNT_W-1:0]     vmin, vmax, imin, imax;
    logic                   in_win, out_win;

    assign vmin = cfg_valid_min  [i*COUNT_W +: COUNT_W];
    assign vmax = cfg_valid_max  [i*COUNT_W +: COUNT_W];
    assign imin = cfg_invalid_min[i*COUNT_W +: COUNT_W];
    assign imax = cfg_invalid_max[i*COUNT_W +: COUNT_W];

    // Toggle synchroniser plus compare register for edge detection.
    always_ff @(posedge clk_10mhz_ext_bufg or negedge core_rst_b) begin
      if (!core_rst_b) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in[i]};
        prev_q <= sync_q[SYNC_STAGES-1];
      end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] ^ prev_q;

    // An edge on the eval cycle is folded into the window being closed.
    assign cnt_inc = (edge_det && (cnt_q != CNT_MAX)) ? cnt_q + COUNT_W'(1) : cnt_q;

    // Saturating edge counter; captured and restarted at the end of each window.
    always_ff @(posedge clk_10mhz_ext_bufg or negedge core_rst_b) begin
      if (!core_rst_b) begin
        cnt_q  <= '0;
        meas_q <= '0;
      end else if (eval) begin
        meas_q <= cnt_inc;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_inc;
      end
    end

    assign los_hit = !edge_det && (timer_q == LOS_TC);

    // Loss-of-signal timer: restarts on each edge, saturates at the terminal count.
    always_ff @(posedge clk_10mhz_ext_bufg or negedge core_rst_b) begin
      if (!core_rst_b) begin
        timer_q <= '0;
        los_q   <= 1'b0;
      end else if (edge_det) begin
        timer_q <= '0;
        los_q   <= 1'b0;
      end else begin
        if (timer_q != LOS_TC) timer_q <= timer_q + LOS_W'(1);
        if (los_hit)           los_q   <= 1'b1;
      end
    end

    assign in_win  = (cnt_inc >= vmin) && (cnt_inc <= vmax);
    assign out_win = (cnt_inc < imin) || (cnt_inc > imax);

    // Hysteresis filter on each closed window; loss of signal overrides it.
    always_ff @(posedge clk_10mhz_ext_bufg or negedge core_rst_b) begin
      if (!core_rst_b) begin
        hyst_q  <= '0;
        valid_q <= 1'b0;
      end else if (los_hit) begin
        hyst_q  <= '0;
        valid_q <= 1'b0;
      end else if (eval && !los_q) begin
        if (in_win) begin
          if (hyst_q == HYST_MAX) valid_q <= 1'b1;
          else                    hyst_q  <= hyst_q + HYST_W'(1);
        end else if (out_win) begin
          if (hyst_q == '0) valid_q <= 1'b0;
          else              hyst_q  <= hyst_q - HYST_W'(1);
        end
      end
    end

    assign meas_count[i*COUNT_W +: COUNT_W] = meas_q;
    assign freq_valid[i] = valid_q;
    assign los[i]        = los_q;
  end

endmodule

// File: tb/tb_freq_monitor_multi.sv
// tb_freq_monitor_multi
// Randomised toggle stimulus against a window/gap based reference model.
module tb_freq_monitor_multi;

  localparam int NCH    = 2;
  localparam int CW     = 8;
  localparam int SYNC   = 3;
  localparam int WIN    = 256;
  localparam int LOSC   = 64;
  localparam int SATMAX = 255;
  localparam int HMAX   = 7;
  localparam int VMIN = 10, VMAX = 11, IMIN = 9, IMAX = 12;

  logic                clk_10mhz_ext_bufg = 1'b0;
  logic                rst_250mhz_int = 1'b1;
  logic [NCH-1:0]      tog_in = '0;
  logic [NCH*CW-1:0]   cfg_valid_min, cfg_valid_max, cfg_invalid_min, cfg_invalid_max;
  logic [NCH*CW-1:0]   meas_count;
  logic                meas_strobe;
  logic [NCH-1:0]      freq_valid;
  logic [NCH-1:0]      los;

  freq_monitor_multi #(
    .NUM_CH(NCH), .GATE_W(8), .COUNT_W(CW), .HYST_W(3),
    .SYNC_STAGES(SYNC), .LOS_CYCLES(LOSC)
  ) dut (
    .clk_10mhz_ext_bufg (clk_10mhz_ext_bufg),
    .rst_250mhz_int     (rst_250mhz_int),
    .tog_in             (tog_in),
    .cfg_valid_min      (cfg_valid_min),
    .cfg_valid_max      (cfg_valid_max),
    .cfg_invalid_min    (cfg_invalid_min),
    .cfg_invalid_max    (cfg_invalid_max),
    .meas_count         (meas_count),
    .meas_strobe        (meas_strobe),
    .freq_valid         (freq_valid),
    .los                (los)
  );

  always #50 clk_10mhz_ext_bufg = ~clk_10mhz_ext_bufg;

  int tests = 0;
  int fails = 0;
  int m = 0;

  // stimulus state
  int       per [NCH];
  int       jit [NCH];
  int       cd  [NCH];
  bit [NCH-1:0] tog_r = '0;
  int       edge_q [NCH][$];

  // reference model state
  int  mcnt [NCH];
  int  mmeas [NCH];
  int  mhyst [NCH];
  int  mlast [NCH];
  bit  mvalid [NCH];
  bit  mlos [NCH];
  bit  mstrobe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, m);
    end
  endtask

  task automatic model_clear();
    mstrobe = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      mcnt[c] = 0; mmeas[c] = 0; mhyst[c] = 0; mlast[c] = -1;
      mvalid[c] = 1'b0; mlos[c] = 1'b0;
      edge_q[c].delete();
      cd[c] = per[c];
    end
  endtask

  // Advance the model over cycle m: window closes on the last cycle of each
  // 256-cycle window; LOS fires once 65+ cycles separate m from the last edge.
  task automatic model_step();
    bit eval;
    eval = ((m % WIN) == WIN - 1);
    mstrobe = eval;
    for (int c = 0; c < NCH; c++) begin
      bit e, hit;
      int cnt_now;
      e = (edge_q[c].size() > 0) && (edge_q[c][0] == m);
      if (e) void'(edge_q[c].pop_front());
      hit = !e && ((m - mlast[c]) >= LOSC + 1);
      cnt_now = mcnt[c] + (e ? 1 : 0);
      if (cnt_now > SATMAX) cnt_now = SATMAX;
      if (eval) begin
        mmeas[c] = cnt_now;
        mcnt[c]  = 0;
        if (!mlos[c]) begin
          if (cnt_now >= VMIN && cnt_now <= VMAX) begin
            if (mhyst[c] == HMAX) mvalid[c] = 1'b1;
            else                  mhyst[c]++;
          end else if (cnt_now < IMIN || cnt_now > IMAX) begin
            if (mhyst[c] == 0) mvalid[c] = 1'b0;
            else               mhyst[c]--;
          end
        end
      end else begin
        mcnt[c] = cnt_now;
      end
      if (e) begin
        mlast[c] = m;
        mlos[c]  = 1'b0;
      end
      if (hit) begin
        mlos[c] = 1'b1; mvalid[c] = 1'b0; mhyst[c] = 0;
      end
    end
  endtask

  task automatic set_mode(input int ch, input int p, input int j);
    per[ch] = p; jit[ch] = j; cd[ch] = p;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (per[c] != 0) begin
          cd[c]--;
          if (cd[c] <= 0) begin
            tog_r[c] = ~tog_r[c];
            edge_q[c].push_back(m + SYNC);
            cd[c] = per[c] + int'($urandom_range(0, jit[c]));
          end
        end
      end
      tog_in = tog_r;
      @(negedge clk_10mhz_ext_bufg);
      chk("strobe", meas_strobe, mstrobe);
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("valid%0d", c), freq_valid[c], mvalid[c]);
        chk($sformatf("los%0d", c), los[c], mlos[c]);
        if (mstrobe) chk($sformatf("meas%0d", c), meas_count[c*CW +: CW], mmeas[c]);
      end
      @(posedge clk_10mhz_ext_bufg);
      #1;
      model_step();
      m++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_10mhz_ext_bufg);
    #7;
    rst_250mhz_int = 1'b1;
    #1;
    chk("rst_meas", meas_count, '0);
    chk("rst_strobe", meas_strobe, 1'b0);
    chk("rst_valid", freq_valid, '0);
    chk("rst_los", los, '0);
    tog_r  = '0;
    tog_in = '0;
    model_clear();
    repeat (3) @(negedge clk_10mhz_ext_bufg);
    rst_250mhz_int = 1'b0;
    @(posedge clk_10mhz_ext_bufg);
    @(posedge clk_10mhz_ext_bufg);
    #1;
    m = 0;
  endtask

  initial begin
    int plist [8];
    plist = '{1, 12, 23, 24, 25, 26, 50, 0};
    cfg_valid_min   = {NCH{8'(VMIN)}};
    cfg_valid_max   = {NCH{8'(VMAX)}};
    cfg_invalid_min = {NCH{8'(IMIN)}};
    cfg_invalid_max = {NCH{8'(IMAX)}};
    set_mode(0, 25, 0);
    set_mode(1, 12, 0);
    do_reset();

    // ch0 in window, ch1 far above it
    run_cycles(10 * WIN);
    chk("ch0_qualified", freq_valid[0], 1'b1);
    chk("ch1_never_valid", freq_valid[1], 1'b0);
    chk("ch1_no_los", los[1], 1'b0);

    // ch0 slows to about half rate
    set_mode(0, 50, 0);
    run_cycles(10 * WIN);
    chk("ch0_disqualified", freq_valid[0], 1'b0);

    set_mode(0, 25, 0);
    run_cycles(10 * WIN);
    chk("ch0_requalified", freq_valid[0], 1'b1);

    // ch0 stops toggling
    set_mode(0, 0, 0);
    run_cycles(300);
    chk("ch0_los", los[0], 1'b1);
    chk("ch0_los_invalid", freq_valid[0], 1'b0);

    set_mode(0, 25, 0);
    run_cycles(10 * WIN);
    chk("ch0_los_cleared", los[0], 1'b0);
    chk("ch0_after_los_valid", freq_valid[0], 1'b1);

    // mid-window reset with ch0 valid
    run_cycles(100);
    do_reset();
    run_cycles(2 * WIN);

    // random phases, one extra reset in the middle
    for (int ph = 0; ph < 14; ph++) begin
      for (int c = 0; c < NCH; c++)
        set_mode(c, plist[$urandom_range(0, 7)], int'($urandom_range(0, 2)));
      if (ph == 7) do_reset();
      run_cycles(int'($urandom_range(600, 2600)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
